// File: rtl/issue_queue.sv
// issue_queue: dual-write, dual-read FIFO between decode and the two issue slots.
// Decode pushes up to two instructions per cycle; issue sees the oldest two and
// retires 0, 1 or 2 of them. The queue also tracks whether the instruction just
// ahead of the head was a branch/jump, for delay-slot marking.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 168,
  parameter int BJ_BIT = 121
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ds_valid_0,
  input  logic                     ds_valid_1,
  input  logic [WIDTH-1:0]         ds_bus_0,
  input  logic [WIDTH-1:0]         ds_bus_1,
  output logic                     ds_allowin,
  output logic                     iss_valid_0,
  output logic                     iss_valid_1,
  output logic [WIDTH-1:0]         iss_bus_0,
  output logic [WIDTH-1:0]         iss_bus_1,
  input  logic                     iss_pop_0,
  input  logic                     iss_pop_1,
  output logic                     preinst_is_bj_0,
  output logic                     preinst_is_bj_1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nx1;
  logic [PTR_W-1:0] wr_addr_1;
  logic             last_bj;
  logic             push_0;
  logic             push_1;
  logic             pop_0;
  logic             pop_1;
  logic [1:0]       n_push;
  logic [1:0]       n_pop;

  // Room for a full pair is judged on the registered count only, so issue-side
  // pops never form a combinational path back to decode.
  assign ds_allowin  = (count <= CNT_W'(DEPTH - 2));
  assign iss_valid_0 = (count != '0);
  assign iss_valid_1 = (count >= CNT_W'(2));

  // Stale array contents are harmless: every read is qualified by a count-based valid.
  assign head_nx1        = head + PTR_W'(1);
  assign iss_bus_0       = mem[head];
  assign iss_bus_1       = mem[head_nx1];
  assign preinst_is_bj_0 = last_bj;
  assign preinst_is_bj_1 = iss_valid_0 & iss_bus_0[BJ_BIT];

  // Qualify push/pop requests; a lone slot-1 instruction lands at tail.
  always_comb begin
    push_0    = ds_valid_0 & ds_allowin & ~flush;
    push_1    = ds_valid_1 & ds_allowin & ~flush;
    pop_0     = iss_pop_0 & iss_valid_0 & ~flush;
    pop_1     = pop_0 & iss_pop_1 & iss_valid_1;
    n_push    = {1'b0, push_0} + {1'b0, push_1};
    n_pop     = {1'b0, pop_0} + {1'b0, pop_1};
    wr_addr_1 = tail + PTR_W'(push_0);
  end

  // Pointer, occupancy and branch-history registers; reset outranks flush,
  // flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      last_bj <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      last_bj <= 1'b0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
      if (pop_0) begin
        last_bj <= pop_1 ? iss_bus_1[BJ_BIT] : iss_bus_0[BJ_BIT];
      end
    end
  end

  // Entry storage; data is never reset, only written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_0) begin
      mem[tail] <= ds_bus_0;
    end
    if (push_1) begin
      mem[wr_addr_1] <= ds_bus_1;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed stimulus pushes expected state records and the
// expected program-order stream into queues; a negedge monitor pops and compares.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int W     = 168;
  localparam int BJ    = 121;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             ds_valid_0 = 1'b0;
  logic             ds_valid_1 = 1'b0;
  logic [W-1:0]     ds_bus_0 = '0;
  logic [W-1:0]     ds_bus_1 = '0;
  logic             ds_allowin;
  logic             iss_valid_0;
  logic             iss_valid_1;
  logic [W-1:0]     iss_bus_0;
  logic [W-1:0]     iss_bus_1;
  logic             iss_pop_0 = 1'b0;
  logic             iss_pop_1 = 1'b0;
  logic             preinst_is_bj_0;
  logic             preinst_is_bj_1;
  logic [3:0]       count;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .WIDTH(W), .BJ_BIT(BJ)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_valid_0(ds_valid_0), .ds_valid_1(ds_valid_1),
    .ds_bus_0(ds_bus_0), .ds_bus_1(ds_bus_1), .ds_allowin(ds_allowin),
    .iss_valid_0(iss_valid_0), .iss_valid_1(iss_valid_1),
    .iss_bus_0(iss_bus_0), .iss_bus_1(iss_bus_1),
    .iss_pop_0(iss_pop_0), .iss_pop_1(iss_pop_1),
    .preinst_is_bj_0(preinst_is_bj_0), .preinst_is_bj_1(preinst_is_bj_1),
    .count(count)
  );

  typedef struct {
    int           id;
    int           cnt;
    logic         v0, v1, alw, pbj0, pbj1;
    logic         hb0, hb1;
    logic [W-1:0] b0, b1;
  } rec_t;

  rec_t         exp_q[$];
  logic [W-1:0] exp_pc[$];
  int           rec_id = 0;
  int           pop_id = 0;
  int           checks = 0;
  int           passes = 0;

  // Entry image: pc in the low word, inverted pc in the top word, b_or_j flag.
  function automatic logic [W-1:0] b(input logic [31:0] pc, input logic bj = 1'b0);
    logic [W-1:0] r;
    r = '0;
    r[31:0] = pc;
    r[W-1:W-32] = ~pc;
    r[BJ] = bj;
    return r;
  endfunction

  task automatic chk1(input string nm, input int id, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s #%0d: got %b expected %b", nm, id, act, exp);
  endtask

  task automatic chkc(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s #%0d: got %0d expected %0d", nm, id, act, exp);
  endtask

  task automatic chkw(input string nm, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
  endtask

  // Record the state the DUT should show after all steps issued so far.
  task automatic exp_st(input int cnt, input logic v0, input logic v1, input logic alw,
                        input logic pbj0, input logic pbj1,
                        input logic hb0 = 1'b0, input logic [W-1:0] b0 = '0,
                        input logic hb1 = 1'b0, input logic [W-1:0] b1 = '0);
    rec_t r;
    r.id = rec_id; rec_id++;
    r.cnt = cnt; r.v0 = v0; r.v1 = v1; r.alw = alw; r.pbj0 = pbj0; r.pbj1 = pbj1;
    r.hb0 = hb0; r.b0 = b0; r.hb1 = hb1; r.b1 = b1;
    exp_q.push_back(r);
  endtask

  // Hold the inputs for one clock edge, then return them to idle.
  task automatic step(input logic v0 = 1'b0, input logic v1 = 1'b0,
                      input logic [W-1:0] b0 = '0, input logic [W-1:0] b1 = '0,
                      input logic p0 = 1'b0, input logic p1 = 1'b0,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    ds_valid_0 = v0; ds_valid_1 = v1; ds_bus_0 = b0; ds_bus_1 = b1;
    iss_pop_0 = p0; iss_pop_1 = p1; flush = fl; reset = rs;
    @(posedge clk);
    #1;
    ds_valid_0 = 1'b0; ds_valid_1 = 1'b0; ds_bus_0 = '0; ds_bus_1 = '0;
    iss_pop_0 = 1'b0; iss_pop_1 = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] pc0, input logic [31:0] pc1,
                           input logic bj0 = 1'b0, input logic bj1 = 1'b0);
    exp_pc.push_back(b(pc0, bj0));
    exp_pc.push_back(b(pc1, bj1));
    step(.v0(1'b1), .v1(1'b1), .b0(b(pc0, bj0)), .b1(b(pc1, bj1)));
  endtask

  // Monitor: compare pending state records and every entry issue retires.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      chkc("count", r.id, int'(count), r.cnt);
      chk1("iss_valid_0", r.id, iss_valid_0, r.v0);
      chk1("iss_valid_1", r.id, iss_valid_1, r.v1);
      chk1("ds_allowin", r.id, ds_allowin, r.alw);
      chk1("preinst_is_bj_0", r.id, preinst_is_bj_0, r.pbj0);
      chk1("preinst_is_bj_1", r.id, preinst_is_bj_1, r.pbj1);
      if (r.hb0) chkw("iss_bus_0", r.id, iss_bus_0, r.b0);
      if (r.hb1) chkw("iss_bus_1", r.id, iss_bus_1, r.b1);
    end
    if (!reset && !flush && iss_pop_0 && exp_pc.size() > 0) begin
      logic [W-1:0] e;
      e = exp_pc.pop_front();
      chk1("pop0_valid", pop_id, iss_valid_0, 1'b1);
      chkw("pop0_order", pop_id, iss_bus_0, e);
      pop_id++;
      if (iss_pop_1 && exp_pc.size() > 0) begin
        e = exp_pc.pop_front();
        chk1("pop1_valid", pop_id, iss_valid_1, 1'b1);
        chkw("pop1_order", pop_id, iss_bus_1, e);
        pop_id++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(.rs(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);

    // One pair from the reset vector
    push_pair(32'hBFC0_0000, 32'hBFC0_0004);
    exp_st(2, 1, 1, 1, 0, 0, 1, b(32'hBFC0_0000), 1, b(32'hBFC0_0004));
    step(.p0(1'b1), .p1(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);

    // Lone slot-1 instruction goes to tail; pop_1 beyond occupancy is masked
    exp_pc.push_back(b(32'h100));
    step(.v1(1'b1), .b1(b(32'h100)));
    exp_st(1, 1, 0, 1, 0, 0, 1, b(32'h100));
    step(.p0(1'b1), .p1(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);
    step(.p0(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);

    // Fill to the full boundary
    for (int i = 0; i < 3; i++) push_pair(32'(32'h1000 + 8 * i), 32'(32'h1004 + 8 * i));
    exp_st(6, 1, 1, 1, 0, 0, 1, b(32'h1000), 1, b(32'h1004));
    push_pair(32'h1018, 32'h101C);
    exp_st(8, 1, 1, 0, 0, 0);
    step(.v0(1'b1), .v1(1'b1), .b0(b(32'h2000)), .b1(b(32'h2004)));
    exp_st(8, 1, 1, 0, 0, 0, 1, b(32'h1000));
    step(.p0(1'b1));
    exp_st(7, 1, 1, 0, 0, 0, 1, b(32'h1004), 1, b(32'h1008));
    step(.v0(1'b1), .b0(b(32'hDEAD)));
    exp_st(7, 1, 1, 0, 0, 0, 1, b(32'h1004));
    for (int i = 0; i < 3; i++) step(.p0(1'b1), .p1(1'b1));
    exp_st(1, 1, 0, 1, 0, 0, 1, b(32'h101C));
    step(.p0(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);

    // Steady state: push two and pop two per cycle, pointers wrap repeatedly
    push_pair(32'h3000, 32'h3004);
    for (int i = 1; i <= 20; i++) begin
      exp_pc.push_back(b(32'(32'h3000 + 8 * i)));
      exp_pc.push_back(b(32'(32'h3004 + 8 * i)));
      step(.v0(1'b1), .v1(1'b1), .b0(b(32'(32'h3000 + 8 * i))), .b1(b(32'(32'h3004 + 8 * i))),
           .p0(1'b1), .p1(1'b1));
      exp_st(2, 1, 1, 1, 0, 0, 1, b(32'(32'h3000 + 8 * i)), 1, b(32'(32'h3004 + 8 * i)));
    end
    step(.p0(1'b1), .p1(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);

    // Branch at head, then its delay slot
    push_pair(32'h200, 32'h204, 1'b1, 1'b0);
    exp_st(2, 1, 1, 1, 0, 1, 1, b(32'h200, 1'b1));
    step(.p0(1'b1));
    exp_st(1, 1, 0, 1, 1, 0, 1, b(32'h204));
    step(.p0(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);
    // Double pop takes the flag from the younger entry
    push_pair(32'h300, 32'h304, 1'b0, 1'b1);
    exp_st(2, 1, 1, 1, 0, 0, 1, b(32'h300), 1, b(32'h304, 1'b1));
    step(.p0(1'b1), .p1(1'b1));
    exp_st(0, 0, 0, 1, 1, 0);

    // Flush with count=5 and push/pop requested in the same cycle
    push_pair(32'h400, 32'h404);
    push_pair(32'h408, 32'h40C);
    exp_pc.push_back(b(32'h410));
    step(.v0(1'b1), .b0(b(32'h410)));
    exp_st(5, 1, 1, 1, 1, 0, 1, b(32'h400));
    step(.v0(1'b1), .v1(1'b1), .b0(b(32'h2100)), .b1(b(32'h2104)),
         .p0(1'b1), .p1(1'b1), .fl(1'b1));
    exp_pc.delete();
    exp_st(0, 0, 0, 1, 0, 0);

    // Reset together with flush, with last_bj set beforehand
    push_pair(32'h500, 32'h504, 1'b1, 1'b0);
    push_pair(32'h508, 32'h50C);
    push_pair(32'h510, 32'h514);
    step(.p0(1'b1));
    exp_st(5, 1, 1, 1, 1, 0, 1, b(32'h504));
    step(.v0(1'b1), .v1(1'b1), .b0(b(32'h2200)), .b1(b(32'h2204)),
         .p0(1'b1), .p1(1'b1), .fl(1'b1), .rs(1'b1));
    exp_pc.delete();
    exp_st(0, 0, 0, 1, 0, 0);

    // Clean restart after reset/flush
    push_pair(32'h600, 32'h604);
    exp_st(2, 1, 1, 1, 0, 0, 1, b(32'h600), 1, b(32'h604));
    step(.p0(1'b1), .p1(1'b1));
    exp_st(0, 0, 0, 1, 0, 0);
    step();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
